// File: rtl/imem_scrub_reader_if.sv
// Scrub port bundle between imem_scrub_reader and the IMEM scrub read/write path.
// master: scrubber drives read strobe/address and writeback; slave: memory side.
interface imem_scrub_reader_if;
    logic        mem_re;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        s_err_in;
    logic        d_err_in;
    logic        scrub_we;
    logic [31:0] scrub_waddr;
    logic [31:0] scrub_wdata;

    modport master (
        output mem_re, mem_raddr, scrub_we, scrub_waddr, scrub_wdata,
        input  mem_rdata, s_err_in, d_err_in
    );

    modport slave (
        input  mem_re, mem_raddr, scrub_we, scrub_waddr, scrub_wdata,
        output mem_rdata, s_err_in, d_err_in
    );
endinterface

// File: rtl/imem_scrub_reader.sv
// Background IMEM scrubber: walks every word at a fixed interval, writes back
// single-bit-corrected words and counts single/double ECC errors.
// Ports: clk, rst (async active-low), enable, pause, bus (scrub port, master),
//   s_count/d_count (saturating), d_err_addr, d_err_flag (sticky), pass_done.
// Build option: SCRUB_DERR_HALT_EN makes a double error park the FSM in HALT.
module imem_scrub_reader #(
    parameter int DEPTH    = 256,
    parameter int INTERVAL = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                pause,
    imem_scrub_reader_if.master bus,
    output logic [15:0]         s_count,
    output logic [15:0]         d_count,
    output logic [31:0]         d_err_addr,
    output logic                d_err_flag,
    output logic                pass_done
);
    localparam int          IW   = $clog2(DEPTH);
    localparam logic [31:0] INTV = 32'(INTERVAL - 1);

    typedef enum logic [2:0] {IDLE, WAIT, READ, CHECK, WBACK, HALT} state_e;

    state_e        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          mem_re_q, mem_re_d;
    logic [31:0]   mem_raddr_q, mem_raddr_d;
    logic          scrub_we_q, scrub_we_d;
    logic [31:0]   scrub_waddr_q, scrub_waddr_d;
    logic [31:0]   scrub_wdata_q, scrub_wdata_d;
    logic [15:0]   s_count_q, s_count_d;
    logic [15:0]   d_count_q, d_count_d;
    logic [31:0]   d_err_addr_q, d_err_addr_d;
    logic          d_err_flag_q, d_err_flag_d;
    logic          pass_done_q, pass_done_d;
    logic          advance;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        mem_re_d      = 1'b0;
        mem_raddr_d   = mem_raddr_q;
        scrub_we_d    = 1'b0;
        scrub_waddr_d = scrub_waddr_q;
        scrub_wdata_d = scrub_wdata_q;
        s_count_d     = s_count_q;
        d_count_d     = d_count_q;
        d_err_addr_d  = d_err_addr_q;
        d_err_flag_d  = d_err_flag_q;
        pass_done_d   = 1'b0;
        advance       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    cnt_d   = INTV;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!pause) begin
                    if (cnt_q == 32'd0) begin
                        // Strobe is registered, so it is raised on entry to READ.
                        state_d     = READ;
                        mem_re_d    = 1'b1;
                        mem_raddr_d = {{(30 - IW){1'b0}}, idx_q, 2'b00};
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
            end
            READ: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (bus.d_err_in) begin
                    if (d_count_q != 16'hFFFF) d_count_d = d_count_q + 16'd1;
                    d_err_addr_d = mem_raddr_q;
                    d_err_flag_d = 1'b1;
`ifdef SCRUB_DERR_HALT_EN
                    state_d = HALT;
`else
                    advance = 1'b1;
`endif
                end else if (bus.s_err_in) begin
                    if (s_count_q != 16'hFFFF) s_count_d = s_count_q + 16'd1;
                    scrub_waddr_d = mem_raddr_q;
                    scrub_wdata_d = bus.mem_rdata;
                    if (pause) begin
                        state_d = WBACK;
                    end else begin
                        scrub_we_d = 1'b1;
                        advance    = 1'b1;
                    end
                end else begin
                    advance = 1'b1;
                end
            end
            WBACK: begin
                if (!pause) begin
                    scrub_we_d = 1'b1;
                    advance    = 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IW'(DEPTH - 1)) pass_done_d = 1'b1;
            cnt_d   = INTV;
            state_d = enable ? WAIT : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= 32'd0;
            idx_q         <= '0;
            mem_re_q      <= 1'b0;
            mem_raddr_q   <= 32'd0;
            scrub_we_q    <= 1'b0;
            scrub_waddr_q <= 32'd0;
            scrub_wdata_q <= 32'd0;
            s_count_q     <= 16'd0;
            d_count_q     <= 16'd0;
            d_err_addr_q  <= 32'd0;
            d_err_flag_q  <= 1'b0;
            pass_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            mem_re_q      <= mem_re_d;
            mem_raddr_q   <= mem_raddr_d;
            scrub_we_q    <= scrub_we_d;
            scrub_waddr_q <= scrub_waddr_d;
            scrub_wdata_q <= scrub_wdata_d;
            s_count_q     <= s_count_d;
            d_count_q     <= d_count_d;
            d_err_addr_q  <= d_err_addr_d;
            d_err_flag_q  <= d_err_flag_d;
            pass_done_q   <= pass_done_d;
        end
    end

    assign bus.mem_re      = mem_re_q;
    assign bus.mem_raddr   = mem_raddr_q;
    assign bus.scrub_we    = scrub_we_q;
    assign bus.scrub_waddr = scrub_waddr_q;
    assign bus.scrub_wdata = scrub_wdata_q;
    assign s_count         = s_count_q;
    assign d_count         = d_count_q;
    assign d_err_addr      = d_err_addr_q;
    assign d_err_flag      = d_err_flag_q;
    assign pass_done       = pass_done_q;
endmodule

// File: tb/tb_imem_scrub_reader.sv
// Directed bench for imem_scrub_reader (DEPTH=8, INTERVAL=4) with a small
// IMEM model that returns data and injected ECC flags one cycle after mem_re.
module tb_imem_scrub_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic pause = 1'b0;
    logic [15:0] s_count, d_count;
    logic [31:0] d_err_addr;
    logic d_err_flag, pass_done;

    always #5 clk = ~clk;

    imem_scrub_reader_if bus ();

    imem_scrub_reader #(.DEPTH(8), .INTERVAL(4)) dut (
        .clk        (clk),
        .rst        (rst_n),
        .enable     (enable),
        .pause      (pause),
        .bus        (bus),
        .s_count    (s_count),
        .d_count    (d_count),
        .d_err_addr (d_err_addr),
        .d_err_flag (d_err_flag),
        .pass_done  (pass_done)
    );

    logic [31:0] mem_word [8];
    logic [7:0]  inj_s = 8'h0;
    logic [7:0]  inj_d = 8'h0;

    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_re ? mem_word[bus.mem_raddr[4:2]] : 32'h0;
        bus.s_err_in  <= bus.mem_re & inj_s[bus.mem_raddr[4:2]];
        bus.d_err_in  <= bus.mem_re & inj_d[bus.mem_raddr[4:2]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rd_cyc[$];
    logic [31:0] rd_addr[$];
    int we_cyc[$];
    logic [31:0] we_addr[$];
    logic [31:0] we_data[$];
    int pass_cyc[$];

    always @(negedge clk) begin
        if (bus.mem_re) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(bus.mem_raddr);
        end
        if (bus.scrub_we) begin
            we_cyc.push_back(cyc);
            we_addr.push_back(bus.scrub_waddr);
            we_data.push_back(bus.scrub_wdata);
        end
        if (pass_done) pass_cyc.push_back(cyc);
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_reads(int n, int budget);
        int k = 0;
        while (rd_cyc.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        chk("read_timeout", 32'(rd_cyc.size() >= n), 32'd1);
    endtask

    task automatic wait_pass(int n, int budget);
        int k = 0;
        while (pass_cyc.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        chk("pass_timeout", 32'(pass_cyc.size() >= n), 32'd1);
    endtask

    task automatic wait_we(int n, int budget);
        int k = 0;
        while (we_cyc.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        chk("we_timeout", 32'(we_cyc.size() >= n), 32'd1);
    endtask

    task automatic chk_all_zero(string pfx);
        chk({pfx, "_mem_re"}, 32'(bus.mem_re), 32'd0);
        chk({pfx, "_mem_raddr"}, bus.mem_raddr, 32'd0);
        chk({pfx, "_scrub_we"}, 32'(bus.scrub_we), 32'd0);
        chk({pfx, "_scrub_waddr"}, bus.scrub_waddr, 32'd0);
        chk({pfx, "_scrub_wdata"}, bus.scrub_wdata, 32'd0);
        chk({pfx, "_s_count"}, 32'(s_count), 32'd0);
        chk({pfx, "_d_count"}, 32'(d_count), 32'd0);
        chk({pfx, "_d_err_addr"}, d_err_addr, 32'd0);
        chk({pfx, "_d_err_flag"}, 32'(d_err_flag), 32'd0);
        chk({pfx, "_pass_done"}, 32'(pass_done), 32'd0);
    endtask

    initial begin
        int n, t, k, m;
        for (int i = 0; i < 8; i++) mem_word[i] = 32'h1000_0000 + 32'(i);
        mem_word[1] = 32'h0000_0008;
        mem_word[5] = 32'hABCD_0000;

        tick(1);
        chk_all_zero("reset");

        // Pass 1: single error on word 1, double error on word 3.
        inj_s[1] = 1'b1;
`ifndef SCRUB_DERR_HALT_EN
        inj_d[3] = 1'b1;
`endif
        rst_n  = 1'b1;
        enable = 1'b1;
        wait_pass(1, 200);
        for (int i = 0; i < 8; i++)
            chk($sformatf("p1_addr%0d", i), rd_addr[i], 32'(i * 4));
        for (int i = 1; i < 8; i++)
            chk($sformatf("p1_gap%0d", i), 32'(rd_cyc[i] - rd_cyc[i-1]), 32'd6);
        chk("p1_pass_time", 32'(pass_cyc[0] - rd_cyc[7]), 32'd2);
        chk("p1_we_num", 32'(we_cyc.size()), 32'd1);
        chk("p1_we_time", 32'(we_cyc[0] - rd_cyc[1]), 32'd2);
        chk("p1_we_addr", we_addr[0], 32'd4);
        chk("p1_we_data", we_data[0], 32'h0000_0008);
        chk("p1_s_count", 32'(s_count), 32'd1);
`ifndef SCRUB_DERR_HALT_EN
        chk("p1_d_count", 32'(d_count), 32'd1);
        chk("p1_d_addr", d_err_addr, 32'd12);
        chk("p1_d_flag", 32'(d_err_flag), 32'd1);
`else
        chk("p1_d_count", 32'(d_count), 32'd0);
`endif
        inj_s = 8'h0;
        inj_d = 8'h0;

        // Pass 2: everything clean now.
        wait_pass(2, 200);
        chk("p2_pass_num", 32'(pass_cyc.size()), 32'd2);
        chk("p2_pass_gap", 32'(pass_cyc[1] - pass_cyc[0]), 32'd48);
        chk("p2_word1_addr", rd_addr[9], 32'd4);
        chk("p2_we_num", 32'(we_cyc.size()), 32'd1);
        chk("p2_s_count", 32'(s_count), 32'd1);

        // Pause for 10 cycles during WAIT stretches the spacing by 10.
        n = rd_cyc.size();
        wait_reads(n + 1, 40);
        t = rd_cyc[n];
        tick(2);
        pause = 1'b1;
        tick(10);
        pause = 1'b0;
        wait_reads(n + 2, 40);
        chk("wait_pause_gap", 32'(rd_cyc[n+1] - t), 32'd16);

        // Pause held across WBACK: strobe withheld until pause falls.
        n = rd_cyc.size();
        k = n % 8;
        mem_word[k] = 32'hABCD_0000 + 32'(k);
        inj_s[k] = 1'b1;
        m = we_cyc.size();
        wait_reads(n + 1, 40);
        t = rd_cyc[n];
        pause = 1'b1;
        tick(12);
        pause = 1'b0;
        wait_we(m + 1, 20);
        chk("wb_pause_time", 32'(we_cyc[m] - t), 32'd13);
        chk("wb_pause_addr", we_addr[m], 32'(k * 4));
        chk("wb_pause_data", we_data[m], 32'hABCD_0000 + 32'(k));
        chk("wb_pause_s_count", 32'(s_count), 32'd2);
        inj_s = 8'h0;

        // Reset while a writeback is pending in WBACK.
        n = rd_cyc.size();
        k = n % 8;
        inj_s[k] = 1'b1;
        wait_reads(n + 1, 40);
        pause = 1'b1;
        tick(3);
        m = we_cyc.size();
        rst_n = 1'b0;
        #1;
        chk_all_zero("wb_reset");
        tick(2);
        inj_s = 8'h0;
        pause = 1'b0;
        rst_n = 1'b1;
        n = rd_cyc.size();
        wait_reads(n + 1, 40);
        chk("post_reset_addr", rd_addr[n], 32'd0);
        chk("post_reset_no_we", 32'(we_cyc.size()), 32'(m));

        // Saturation of the single-error counter.
        n = rd_cyc.size();
        wait_reads(n + 1, 40);
        tick(2);
        force dut.s_count_q = 16'hFFFE;
        tick(1);
        release dut.s_count_q;
        tick(1);
        chk("sat_preload", 32'(s_count), 32'h0000_FFFE);
        m = we_cyc.size();
        n = rd_cyc.size();
        inj_s = 8'hFF;
        wait_reads(n + 2, 40);
        chk("sat_first", 32'(s_count), 32'h0000_FFFF);
        wait_reads(n + 4, 60);
        inj_s = 8'h0;
        tick(3);
        chk("sat_hold", 32'(s_count), 32'h0000_FFFF);
        chk("sat_we_num", 32'(we_cyc.size()), 32'(m + 3));

`ifdef SCRUB_DERR_HALT_EN
        // Double error on word 3 parks the scrubber.
        inj_d[3] = 1'b1;
        begin
            int b = 0;
            while (!(rd_addr.size() > 0 && rd_addr[rd_addr.size()-1] == 32'd12)
                   && b < 100) begin
                tick(1);
                b++;
            end
        end
        tick(3);
        chk("halt_d_addr", d_err_addr, 32'd12);
        chk("halt_d_count", 32'(d_count), 32'd1);
        chk("halt_d_flag", 32'(d_err_flag), 32'd1);
        n = rd_cyc.size();
        m = we_cyc.size();
        tick(100);
        chk("halt_no_read", 32'(rd_cyc.size()), 32'(n));
        chk("halt_no_we", 32'(we_cyc.size()), 32'(m));
        chk("halt_flag_sticky", 32'(d_err_flag), 32'd1);
        inj_d = 8'h0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
